// File: rtl/regfile_writeback_unit.sv
// Register file writer: round-robin arbitration of EXU/LSU results onto a
// registered write port, plus a per-register pending-write scoreboard for RAW checks.
module regfile_writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]  cnt [NREG];
  logic                  last_lsu;
  logic                  exu_gnt, lsu_gnt, gnt;
  logic [ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  iss_acc, ret;
  logic [NREG-1:0]       inc_vec, dec_vec;

  // LSU wins a tie unless it was granted last; reset blocks every handshake
  always_comb begin
    exu_gnt   = !rst && exu_valid && (!lsu_valid || last_lsu);
    lsu_gnt   = !rst && lsu_valid && (!exu_valid || !last_lsu);
    gnt       = exu_gnt || lsu_gnt;
    gnt_rd    = lsu_gnt ? lsu_rd : exu_rd;
    gnt_data  = lsu_gnt ? lsu_data : exu_data;
    exu_ready = exu_gnt;
    lsu_ready = lsu_gnt;
  end

  always_comb begin
    iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX);
    iss_acc   = !rst && iss_valid && iss_ready && (iss_rd != '0);
    ret       = gnt && (gnt_rd != '0);
    inc_vec   = iss_acc ? (NREG'(1) << iss_rd) : '0;
    dec_vec   = ret ? (NREG'(1) << gnt_rd) : '0;
  end

  // The registered write still in flight counts as a pending write
  always_comb begin
    busy1 = (raddr1 != '0) && ((cnt[raddr1] != '0) || (rf_we && rf_waddr == raddr1));
    busy2 = (raddr2 != '0) && ((cnt[raddr2] != '0) || (rf_we && rf_waddr == raddr2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      if (ret && !inc_vec[gnt_rd])
        retire_nonzero: assert (cnt[gnt_rd] != '0);
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_WIDTH'(1);
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (gnt) last_lsu <= lsu_gnt;
      rf_we <= ret;
      if (ret) begin
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the scoreboard and write port.
module tb_regfile_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  raddr1, raddr2;
  logic        busy1, busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_writeback_unit dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: outstanding writes per register, last winner, and the write port
  int          pend [32];
  bit          m_last_lsu;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit iv, input int ird,
                      input bit ev, input int erd, input logic [31:0] ed,
                      input bit lv, input int lrd, input logic [31:0] ld,
                      input int ra1, input int ra2);
    bit eg, lg, irdy, b1, b2;
    int grd;
    logic [31:0] gdata;
    @(negedge clk);
    rst = r; iss_valid = iv; iss_rd = 5'(ird);
    exu_valid = ev; exu_rd = 5'(erd); exu_data = ed;
    lsu_valid = lv; lsu_rd = 5'(lrd); lsu_data = ld;
    raddr1 = 5'(ra1); raddr2 = 5'(ra2);
    #1;
    eg   = !r && ev && (!lv || m_last_lsu);
    lg   = !r && lv && (!ev || !m_last_lsu);
    irdy = (ird == 0) || (pend[ird] < 3);
    b1   = (ra1 != 0) && (pend[ra1] != 0 || (m_we && m_waddr == ra1));
    b2   = (ra2 != 0) && (pend[ra2] != 0 || (m_we && m_waddr == ra2));
    chk("exu_ready", 32'(exu_ready), 32'(eg));
    chk("lsu_ready", 32'(lsu_ready), 32'(lg));
    if (!r) begin
      chk("iss_ready", 32'(iss_ready), 32'(irdy));
      chk("busy1", 32'(busy1), 32'(b1));
      chk("busy2", 32'(busy2), 32'(b2));
    end
    @(posedge clk);
    if (r) begin
      foreach (pend[i]) pend[i] = 0;
      m_last_lsu = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
    end else begin
      if (iv && irdy && ird != 0) pend[ird]++;
      grd = lg ? lrd : erd;
      gdata = lg ? ld : ed;
      if (eg || lg) m_last_lsu = lg;
      m_we = (eg || lg) && grd != 0;
      if (m_we) begin
        pend[grd]--;
        m_waddr = grd;
        m_wdata = gdata;
      end
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
  endtask

  task automatic idle(input int ra1, input int ra2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2);
  endtask

  // choose a destination that legally has a pending write (0 if none found)
  function automatic int pick_pending();
    for (int t = 0; t < 8; t++) begin
      int c = int'($urandom_range(1, 7));
      if (pend[c] > 0) return c;
    end
    return 0;
  endfunction

  initial begin
    rst = 1; iss_valid = 0; iss_rd = 0; exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; raddr1 = 0; raddr2 = 0;
    foreach (pend[i]) pend[i] = 0;
    m_last_lsu = 0; m_we = 0; m_waddr = 0; m_wdata = '0;

    // reset with both result sources asserting valid
    step(1, 0, 0, 1, 3, 32'h1, 1, 4, 32'h2, 0, 0);
    step(1, 1, 6, 1, 3, 32'h1, 1, 4, 32'h2, 0, 0);
    for (int a = 0; a < 32; a += 2) idle(a, a + 1);

    // single issue then EXU writeback
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // simultaneous EXU/LSU results, LSU first then EXU
    step(0, 1, 3, 0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 1, 4, 0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 0, 0, 1, 3, 32'hA, 1, 4, 32'hB, 3, 4);
    step(0, 0, 0, 1, 3, 32'hA, 1, 4, 32'hB, 3, 4);
    idle(3, 4);
    idle(3, 4);

    // counter saturation on rd=7
    for (int k = 0; k < 4; k++) step(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 7, 0);
    step(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1, 7, 32'h70 + 32'(k), 7, 0);
    idle(7, 0);
    idle(7, 0);

    // same-cycle issue and retire on rd=9
    step(0, 1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 1, 9, 1, 9, 32'h99, 0, 0, 0, 9, 0);
    idle(9, 0);
    step(0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 9, 0);
    idle(9, 0);
    idle(9, 0);

    // rd=0 result is accepted but never written
    step(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
    idle(0, 0);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      bit ev, lv;
      int erd, lrd;
      ev  = ($urandom_range(0, 2) != 0);
      lv  = ($urandom_range(0, 2) != 0);
      erd = ($urandom_range(0, 9) == 0) ? 0 : pick_pending();
      lrd = ($urandom_range(0, 9) == 0) ? 0 : pick_pending();
      // a lone pending write must not be claimed by both sources in one cycle
      if (ev && lv && erd == lrd && erd != 0 && pend[erd] < 2) lv = 0;
      step(0, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
           ev, erd, $urandom, lv, lrd, $urandom,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
